// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses the combinational imem and
// loads the IF/ID register. Every output is a register; priority is reset > redirect > halt > stall.
module fetch_unit #(
  parameter int                     PC_WIDTH    = 8,
  parameter int                     INSTR_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [PC_WIDTH-1:0]    pc_output,
  input  logic [INSTR_WIDTH-1:0] instruction_input,
  input  logic                   stall,
  input  logic                   redirect_valid,
  input  logic [PC_WIDTH-1:0]    redirect_target,
  input  logic                   halt_request,
  output logic [INSTR_WIDTH-1:0] if_id_instruction,
  output logic [PC_WIDTH-1:0]    if_id_pc,
  output logic [PC_WIDTH-1:0]    if_id_pc_plus1,
  output logic                   if_id_valid,
  output logic [15:0]            fetch_count,
  output logic [15:0]            bubble_count
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [PC_WIDTH-1:0]    ipc_q, ipc_d;
  logic [PC_WIDTH-1:0]    ipc1_q, ipc1_d;
  logic                   vld_q, vld_d;
  logic [15:0]            fcnt_q, fcnt_d;
  logic [15:0]            bcnt_q, bcnt_d;
  logic                   load_bubble;
  logic                   load_fetch;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    ipc_d       = ipc_q;
    ipc1_d      = ipc1_q;
    vld_d       = vld_q;
    fcnt_d      = fcnt_q;
    bcnt_d      = bcnt_q;
    load_bubble = 1'b0;
    load_fetch  = 1'b0;

    case (state_q)
      BOOT: begin
        load_bubble = 1'b1;
        state_d     = RUN;
        if (redirect_valid) pc_d = redirect_target;
      end
      RUN: begin
        if (redirect_valid) begin
          load_bubble = 1'b1;
          pc_d        = redirect_target;
        end else if (halt_request) begin
          load_bubble = 1'b1;
          state_d     = HALT;
        end else if (!stall) begin
          load_fetch = 1'b1;
        end
      end
      HALT: begin
        // Stall is irrelevant while halted; only a redirect restarts fetch.
        load_bubble = 1'b1;
        if (redirect_valid) begin
          pc_d    = redirect_target;
          state_d = RUN;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase

    // A bubble keeps if_id_pc/if_id_pc_plus1 from the last real instruction.
    if (load_bubble) begin
      vld_d   = 1'b0;
      instr_d = '0;
      bcnt_d  = (bcnt_q == 16'hFFFF) ? bcnt_q : bcnt_q + 16'd1;
    end

    if (load_fetch) begin
      instr_d = instruction_input;
      ipc_d   = pc_q;
      ipc1_d  = pc_q + 1'b1;
      vld_d   = 1'b1;
      fcnt_d  = (fcnt_q == 16'hFFFF) ? fcnt_q : fcnt_q + 16'd1;
      pc_d    = pc_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      ipc_q   <= '0;
      ipc1_q  <= '0;
      vld_q   <= 1'b0;
      fcnt_q  <= '0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      ipc1_q  <= ipc1_d;
      vld_q   <= vld_d;
      fcnt_q  <= fcnt_d;
      bcnt_q  <= bcnt_d;
    end
  end

  assign pc_output         = pc_q;
  assign if_id_instruction = instr_q;
  assign if_id_pc          = ipc_q;
  assign if_id_pc_plus1    = ipc1_q;
  assign if_id_valid       = vld_q;
  assign fetch_count       = fcnt_q;
  assign bubble_count      = bcnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a reference model predicts the state after every edge,
// a negedge monitor pops and compares; directed scenarios are followed by random traffic.
module tb_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic        halt_request;
  logic [7:0]  redirect_target;
  logic [7:0]  pc_output;
  logic [7:0]  if_id_pc;
  logic [7:0]  if_id_pc_plus1;
  logic [15:0] instruction_input;
  logic [15:0] if_id_instruction;
  logic [15:0] fetch_count;
  logic [15:0] bubble_count;
  logic        if_id_valid;

  logic [15:0] imem [256];
  assign instruction_input = imem[pc_output];

  fetch_unit #(.PC_WIDTH(8), .INSTR_WIDTH(16), .RESET_PC(8'h00)) dut (
    .clk               (clk),
    .reset             (reset),
    .pc_output         (pc_output),
    .instruction_input (instruction_input),
    .stall             (stall),
    .redirect_valid    (redirect_valid),
    .redirect_target   (redirect_target),
    .halt_request      (halt_request),
    .if_id_instruction (if_id_instruction),
    .if_id_pc          (if_id_pc),
    .if_id_pc_plus1    (if_id_pc_plus1),
    .if_id_valid       (if_id_valid),
    .fetch_count       (fetch_count),
    .bubble_count      (bubble_count)
  );

  typedef struct {
    int pc;
    int instr;
    int ipc;
    int ipc1;
    int vld;
    int fc;
    int bc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: fetch-stage behaviour described as "what happens this cycle".
  int m_pc, m_instr, m_ipc, m_ipc1, m_vld, m_fc, m_bc;
  bit m_booting, m_halted, m_bubble;

  function automatic int sat(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_pc = 0; m_instr = 0; m_ipc = 0; m_ipc1 = 0; m_vld = 0; m_fc = 0; m_bc = 0;
      m_booting = 1'b1;
      m_halted  = 1'b0;
    end else begin
      m_bubble = 1'b0;
      if (m_booting) begin
        m_bubble  = 1'b1;
        m_booting = 1'b0;
        if (redirect_valid) m_pc = redirect_target;
      end else if (m_halted) begin
        m_bubble = 1'b1;
        if (redirect_valid) begin
          m_pc     = redirect_target;
          m_halted = 1'b0;
        end
      end else if (redirect_valid) begin
        m_bubble = 1'b1;
        m_pc     = redirect_target;
      end else if (halt_request) begin
        m_bubble = 1'b1;
        m_halted = 1'b1;
      end else if (!stall) begin
        m_instr = imem[m_pc];
        m_ipc   = m_pc;
        m_ipc1  = (m_pc + 1) % 256;
        m_vld   = 1;
        m_fc    = sat(m_fc + 1);
        m_pc    = (m_pc + 1) % 256;
      end
      if (m_bubble) begin
        m_vld   = 0;
        m_instr = 0;
        m_bc    = sat(m_bc + 1);
      end
    end
    q.push_back('{m_pc, m_instr, m_ipc, m_ipc1, m_vld, m_fc, m_bc});
  end

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("pc_output",         int'(pc_output),         e.pc);
      check("if_id_instruction", int'(if_id_instruction), e.instr);
      check("if_id_pc",          int'(if_id_pc),          e.ipc);
      check("if_id_pc_plus1",    int'(if_id_pc_plus1),    e.ipc1);
      check("if_id_valid",       int'(if_id_valid),       e.vld);
      check("fetch_count",       int'(fetch_count),       e.fc);
      check("bubble_count",      int'(bubble_count),      e.bc);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; halt_request = 1'b0;
    redirect_target = 8'h00;
    for (int i = 0; i < 256; i++) imem[i] = 16'($urandom);
    imem[0] = 16'h0050;
    imem[1] = 16'h08D2;

    cyc(2);
    check("reset_pc", int'(pc_output), 0);
    check("reset_valid", int'(if_id_valid), 0);
    reset = 1'b0;

    // Boot: one bubble, then words at 0 and 1.
    cyc(1);
    check("boot_bubble", int'(if_id_valid), 0);
    cyc(1);
    check("first_instr", int'(if_id_instruction), 16'h0050);
    check("first_pc1", int'(if_id_pc_plus1), 1);
    cyc(1);
    check("second_instr", int'(if_id_instruction), 16'h08D2);
    check("boot_fetch_count", int'(fetch_count), 2);
    check("boot_bubble_count", int'(bubble_count), 1);

    // Stall while IF/ID holds pc=4.
    cyc(3);
    check("pre_stall_pc", int'(if_id_pc), 4);
    stall = 1'b1;
    cyc(3);
    check("stall_ifid_pc", int'(if_id_pc), 4);
    check("stall_pc_output", int'(pc_output), 5);
    check("stall_fetch_count", int'(fetch_count), 5);
    stall = 1'b0;
    cyc(1);
    check("post_stall_pc", int'(if_id_pc), 5);

    // Redirect from 0x0C to 0x0F.
    cyc(6);
    check("pre_redirect_pc", int'(pc_output), 8'h0C);
    redirect_valid = 1'b1; redirect_target = 8'h0F;
    cyc(1);
    redirect_valid = 1'b0;
    check("redirect_bubble", int'(if_id_valid), 0);
    check("redirect_pc_output", int'(pc_output), 8'h0F);
    cyc(1);
    check("redirect_target_pc", int'(if_id_pc), 8'h0F);

    // Redirect and stall in the same cycle.
    stall = 1'b1; redirect_valid = 1'b1; redirect_target = 8'h02;
    cyc(1);
    stall = 1'b0; redirect_valid = 1'b0;
    check("redir_stall_pc", int'(pc_output), 8'h02);
    check("redir_stall_valid", int'(if_id_valid), 0);

    // Halt at pc=7, stall toggling, then resume at 0.
    cyc(5);
    check("pre_halt_pc", int'(pc_output), 7);
    halt_request = 1'b1;
    cyc(1);
    halt_request = 1'b0;
    for (int i = 0; i < 10; i++) begin
      stall = i[0];
      cyc(1);
      check("halt_pc", int'(pc_output), 7);
      check("halt_valid", int'(if_id_valid), 0);
    end
    stall = 1'b0;
    redirect_valid = 1'b1; redirect_target = 8'h00;
    cyc(1);
    redirect_valid = 1'b0;
    cyc(1);
    check("resume_pc", int'(if_id_pc), 0);
    check("resume_valid", int'(if_id_valid), 1);

    // Wrap from 0xFE.
    redirect_valid = 1'b1; redirect_target = 8'hFE;
    cyc(1);
    redirect_valid = 1'b0;
    cyc(1);
    check("wrap_fe", int'(if_id_pc), 8'hFE);
    cyc(1);
    check("wrap_ff", int'(if_id_pc), 8'hFF);
    check("wrap_ff_plus1", int'(if_id_pc_plus1), 8'h00);
    cyc(1);
    check("wrap_00", int'(if_id_pc), 8'h00);

    // Reset coincident with a redirect.
    reset = 1'b1; redirect_valid = 1'b1; redirect_target = 8'h33;
    cyc(1);
    check("rst_redir_pc", int'(pc_output), 0);
    check("rst_redir_fc", int'(fetch_count), 0);
    check("rst_redir_bc", int'(bubble_count), 0);
    check("rst_redir_ipc", int'(if_id_pc), 0);
    reset = 1'b0; redirect_valid = 1'b0;

    // Random traffic, including occasional resets.
    for (int i = 0; i < 3000; i++) begin
      stall           = ($urandom % 4) == 0;
      redirect_valid  = ($urandom % 8) == 0;
      redirect_target = 8'($urandom_range(0, 255));
      halt_request    = ($urandom % 16) == 0;
      reset           = ($urandom % 200) == 0;
      cyc(1);
    end
    reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; halt_request = 1'b0;
    cyc(2);
    @(negedge clk);
    #1;
    check("scoreboard_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
